// File: rtl/cg_cgg_filt.sv
// cg_cgg_filt: per-channel f=(a&~b&e)|g, registered and stability-filtered.
// Optional glitch counters: define CG_GLITCH_CNT_EN.
module cg_cgg_filt #(
  parameter int CH     = 4,
  parameter int STABLE = 3,
  parameter int GW     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CH-1:0]    a,
  input  logic [CH-1:0]    b,
  input  logic [CH-1:0]    e,
  input  logic [CH-1:0]    g,
  output logic [CH-1:0]    w,
  output logic [CH-1:0]    chg,
  output logic [CH*GW-1:0] glitch_cnt
);

  localparam int CW = $clog2(STABLE + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CH-1:0]         f;
  logic [CH-1:0]         r_q, r_d;
  logic [CH-1:0]         w_q, w_d;
  logic [CH-1:0]         chg_q, chg_d;
  logic [CH-1:0][CW-1:0] cnt_q, cnt_d;

  assign f   = (a & ~b & e) | g;
  assign w   = w_q;
  assign chg = chg_q;

  // Filter next state: count edges where the sample disagrees with w.
  always_comb begin
    r_d   = r_q;
    w_d   = w_q;
    chg_d = '0;
    cnt_d = cnt_q;
    if (en) begin
      r_d = f;
      for (int i = 0; i < CH; i++) begin
        if (r_q[i] == w_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == LAST) begin
          w_d[i]   = r_q[i];
          cnt_d[i] = '0;
          chg_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + ONE;
        end
      end
    end
  end

  // Sample, filter and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      w_q   <= '0;
      chg_q <= '0;
      cnt_q <= '0;
    end else begin
      r_q   <= r_d;
      w_q   <= w_d;
      chg_q <= chg_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef CG_GLITCH_CNT_EN
  localparam logic [GW-1:0] GONE = GW'(1);

  logic [CH-1:0][GW-1:0] gc_q, gc_d;

  // A glitch is a pending candidate that reverted; counters saturate.
  always_comb begin
    gc_d = gc_q;
    if (en) begin
      for (int i = 0; i < CH; i++) begin
        if (r_q[i] == w_q[i] && cnt_q[i] != '0
            && gc_q[i] != '1) begin
          gc_d[i] = gc_q[i] + GONE;
        end
      end
    end
  end

  // Glitch counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gc_q <= '0;
    end else begin
      gc_q <= gc_d;
    end
  end

  assign glitch_cnt = gc_q;
`else
  assign glitch_cnt = '0;
`endif

endmodule

// File: tb/tb_cg_cgg_filt.sv
// tb_cg_cgg_filt: scoreboard bench for cg_cgg_filt (CH=4, STABLE=3, GW=8).
// Reference model tracks sample history per channel.
module tb_cg_cgg_filt;

  localparam int CH  = 4;
  localparam int STB = 3;
  localparam int GW  = 8;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [CH-1:0]    a, b, e, g;
  logic [CH-1:0]    w, chg;
  logic [CH*GW-1:0] glitch_cnt;

  cg_cgg_filt #(.CH(CH), .STABLE(STB), .GW(GW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .a(a), .b(b), .e(e), .g(g),
    .w(w), .chg(chg), .glitch_cnt(glitch_cnt)
  );

  typedef struct {
    logic [CH-1:0]    w;
    logic [CH-1:0]    chg;
    logic [CH*GW-1:0] gc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  logic [CH-1:0] r_m, w_m, chg_m;
  int            gm[CH];
  bit            hist[CH][$];

  initial begin
    clk = 1'b0;
    #10;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, req, $time);
  endtask

  function automatic logic [CH*GW-1:0] gc_exp();
    logic [CH*GW-1:0] v;
    v = '0;
`ifdef CG_GLITCH_CNT_EN
    for (int i = 0; i < CH; i++) v[i*GW +: GW] = GW'(gm[i]);
`endif
    return v;
  endfunction

  task automatic model_reset();
    r_m = '0; w_m = '0; chg_m = '0;
    for (int i = 0; i < CH; i++) begin
      gm[i] = 0;
      hist[i].delete();
    end
  endtask

  // w takes a new value once the last STB samples all disagree with it.
  task automatic model_edge();
    logic [CH-1:0] f;
    int n;
    bit s, ok;
    f = (a & ~b & e) | g;
    chg_m = '0;
    if (!en) return;
    for (int i = 0; i < CH; i++) begin
      s = r_m[i];
      hist[i].push_back(s);
      if (hist[i].size() > 8) void'(hist[i].pop_front());
      n = hist[i].size();
      if (s == w_m[i]) begin
        if (n >= 2 && hist[i][n-2] != w_m[i] && gm[i] < 255)
          gm[i]++;
      end else begin
        ok = (n >= STB);
        for (int j = n - STB; j < n; j++)
          if (j >= 0 && hist[i][j] == w_m[i]) ok = 0;
        if (ok) begin
          w_m[i]   = s;
          chg_m[i] = 1'b1;
        end
      end
    end
    r_m = f;
  endtask

  task automatic push_exp();
    exp_t x;
    x.w = w_m; x.chg = chg_m; x.gc = gc_exp();
    exp_q.push_back(x);
  endtask

  task automatic cyc(input logic rs, input logic ev,
                     input logic [CH-1:0] av, bv, evv, gv);
    logic was;
    @(negedge clk);
    was = rst_n;
    rst_n = rs; en = ev;
    a = av; b = bv; e = evv; g = gv;
    if (!rs) begin
      model_reset();
      push_exp();
      if (was) begin
        #1;
        chk("async_w", 64'(w), 64'(0));
        chk("async_chg", 64'(chg), 64'(0));
        chk("async_gc", 64'(glitch_cnt), 64'(0));
      end
    end else begin
      model_edge();
      push_exp();
    end
  endtask

  // Monitor: one expected entry per clock edge.
  always begin
    exp_t x;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      chk("w", 64'(w), 64'(x.w));
      chk("chg", 64'(chg), 64'(x.chg));
      chk("glitch_cnt", 64'(glitch_cnt), 64'(x.gc));
    end
  end

  initial begin
    logic [CH-1:0] ra, rb, re, rg;
    logic          ren;
    int            hold;
    rst_n = 1'b1; en = 1'b0;
    a = CH'($urandom); b = CH'($urandom);
    e = CH'($urandom); g = CH'($urandom);
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_w", 64'(w), 64'(0));
    chk("rst_chg", 64'(chg), 64'(0));
    chk("rst_gc", 64'(glitch_cnt), 64'(0));
    for (int k = 0; k < 2; k++)
      cyc(0, 1, CH'($urandom), CH'($urandom),
          CH'($urandom), CH'($urandom));
    // ch0 gate function true, all else quiet
    for (int k = 0; k < 6; k++) cyc(1, 1, 4'h1, 4'h0, 4'h1, 4'h0);
    // ch1 two-cycle g pulses, repeated to saturate
    for (int k = 0; k < 300; k++) begin
      cyc(1, 1, 4'h1, 4'h0, 4'h1, 4'h2);
      cyc(1, 1, 4'h1, 4'h0, 4'h1, 4'h2);
      cyc(1, 1, 4'h1, 4'h0, 4'h1, 4'h0);
      cyc(1, 1, 4'h1, 4'h0, 4'h1, 4'h0);
    end
    // ch2 held true with en toggling
    for (int k = 0; k < 10; k++)
      cyc(1, 1'(k % 2 == 0), 4'h1, 4'h0, 4'h1, 4'h4);
    cyc(0, 1, 4'h0, 4'h0, 4'h0, 4'h0);
    cyc(1, 1, 4'h0, 4'h0, 4'h0, 4'h0);
    // all channels true, reset after two edges
    cyc(1, 1, 4'h0, 4'h0, 4'h0, 4'hf);
    cyc(1, 1, 4'h0, 4'h0, 4'h0, 4'hf);
    cyc(0, 1, 4'h0, 4'h0, 4'h0, 4'hf);
    for (int k = 0; k < 6; k++) cyc(1, 1, 4'h0, 4'h0, 4'h0, 4'hf);
    // randomized phase with held input patterns
    for (int k = 0; k < 120; k++) begin
      ra = CH'($urandom); rb = CH'($urandom);
      re = CH'($urandom); rg = CH'($urandom);
      hold = $urandom_range(1, 5);
      for (int h = 0; h < hold; h++) begin
        ren = ($urandom_range(0, 4) != 0);
        cyc(($urandom_range(0, 60) != 0), ren, ra, rb, re, rg);
      end
    end
    cyc(1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
    cyc(1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
    @(posedge clk);
    #2;
    chk("drain", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
